// File: rtl/div_unit.sv
// Purpose: iterative restoring divider for DIV/DIVU, producing {remainder, quotient} for HI/LO.
// Latency: WIDTH+1 edges from start (operand latch plus WIDTH shift-subtract steps), 2 edges for a zero divisor.
// Backpressure: stall holds the pipeline while start is pending; the result is held in END until start drops.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    // Bit 2*WIDTH is the remainder headroom so the shifted partial remainder never overflows.
    logic [2*WIDTH:0]   work;
    logic [WIDTH-1:0]   divisor_q;
    logic               neg_q;
    logic               neg_r;

    logic               accept;
    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH:0]   step;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes; unary minus of the most negative value yields its unsigned magnitude.
    always_comb begin
        accept  = start && !annul;
        op1_abs = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        op2_abs = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    end

    // One restoring step: subtract the divisor from the shifted partial remainder, keep it if non-negative.
    always_comb begin
        diff     = work[2*WIDTH:WIDTH-1] - {2'b00, divisor_q};
        step     = diff[WIDTH+1] ? {work[2*WIDTH-1:0], 1'b0}
                                 : {diff[WIDTH:0], work[WIDTH-2:0], 1'b1};
        quot     = step[WIDTH-1:0];
        rem      = step[2*WIDTH-1:WIDTH];
        quot_fix = neg_q ? -quot : quot;
        rem_fix  = neg_r ? -rem  : rem;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        stall     = 1'b0;
        case (state)
            FREE: begin
                if (accept) begin
                    state_nxt = (opdata2 == '0) ? BYZERO : ON;
                end
            end
            BYZERO: state_nxt = END;
            ON: begin
                if (annul) begin
                    state_nxt = FREE;
                end else if (cnt == LAST) begin
                    state_nxt = END;
                end
            end
            END: begin
                ready = 1'b1;
                if (!start) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
        stall = start && !ready && !annul;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, iteration datapath and result load.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            work      <= '0;
            divisor_q <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                FREE: begin
                    if (accept) begin
                        work      <= {{(WIDTH + 1){1'b0}}, op1_abs};
                        divisor_q <= op2_abs;
                        neg_q     <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_r     <= signed_div && opdata1[WIDTH-1];
                        cnt       <= '0;
                    end
                end
                BYZERO: result <= '0;
                ON: begin
                    if (!annul) begin
                        work <= step;
                        cnt  <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            result <= {rem_fix, quot_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Purpose: directed self-checking bench for div_unit (WIDTH=32).
// Latency: edge k is the edge just before start is raised; the operand latch happens at edge k+1.
// Backpressure: start is held until ready is seen, optionally for extra cycles in END.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after an edge (edge k). Raises start, waits for ready with a cycle budget,
    // checks latency, stall, result, optional END hold, and return to FREE.
    task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int exp_lat, input int hold);
        int lat;
        int stall_bad;
        lat        = -1;
        stall_bad  = 0;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        annul      = 1'b0;
        #1;
        check({tag, "_stall_start"}, 64'(stall), 64'd1);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                // Operands must already be captured; a zero divisor here would divert the FSM.
                opdata1    = ~a;
                opdata2    = 32'd0;
                signed_div = ~sd;
            end
            if (ready) begin
                lat = n;
                break;
            end
            if (!stall) stall_bad++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_wait"}, 64'(stall_bad), 64'd0);
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_ready"}, 64'(stall), 64'd0);
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_hold_ready%0d", tag, i), 64'(ready), 64'd1);
            check($sformatf("%s_hold_result%0d", tag, i), result, exp);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_ready"}, 64'(ready), 64'd0);
        check({tag, "_drop_result"}, result, exp);
    endtask

    initial begin
        logic seen_ready;
        resetn     = 1'b0;
        start      = 1'b1;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;

        // Reset state; stall stays combinational during reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_stall_start", 64'(stall), 64'd1);
        annul = 1'b1;
        #1;
        check("rst_stall_annul", 64'(stall), 64'd0);
        start  = 1'b0;
        annul  = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'h0000000E}, 33, 0);
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
        run_op("divu_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, {32'h00000001, 32'h7FFFFFFC}, 33, 0);
        run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, 0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 0);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
        run_op("divu_0_5", 1'b0, 32'd0, 32'd5, 64'd0, 33, 0);

        // Annul on the 10th ON cycle: ON cycle 1 follows the latch at k+1, so annul follows edge k+10.
        seen_ready = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (ready) seen_ready = 1'b1;
        end
        annul = 1'b1;
        #1;
        check("annul_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        if (ready) seen_ready = 1'b1;
        check("annul_ready_seen", 64'(seen_ready), 64'd0);
        check("annul_result", result, 64'd0);
        // Full latency here proves the FSM was back in FREE after the annul edge.
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

        // Reset on the 20th ON cycle, then a start on the first post-reset edge with a 5-cycle END hold.
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        start  = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_result", result, 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        resetn = 1'b1;
        run_op("post_rst_1000_10", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits; the division takes WIDTH iteration cycles.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit, meaning reset; reset is synchronous and active-low.
REQ-004 SHALL have port signed_div, input, 1 bit: 1 = DIV (signed), 0 = DIVU (unsigned), decoded from alucontrol.
REQ-005 SHALL have port opdata1, input, WIDTH bits, meaning the dividend.
REQ-006 SHALL have port opdata2, input, WIDTH bits, meaning the divisor.
REQ-007 SHALL have port start, input, 1 bit, meaning a request to begin division; it is held high until ready is seen.
REQ-008 SHALL have port annul, input, 1 bit, meaning cancel of the in-flight division on an exception flush.
REQ-009 SHALL have port result, output, 2*WIDTH bits: {remainder, quotient}, where the upper half goes to HI and the lower half to LO.
REQ-010 SHALL have port ready, output, 1 bit, meaning result is valid.
REQ-011 SHALL have port stall, output, 1 bit, meaning a pipeline stall request, driven combinationally as start AND NOT ready AND NOT annul.

Function
REQ-012 SHALL implement a four-state FSM with states FREE, BYZERO, ON and END.
REQ-013 In FREE with start=1 and annul=0, the block SHALL latch signed_div, opdata1 and opdata2 and move to BYZERO if opdata2==0, else to ON with the iteration counter set to 0.
REQ-014 In FREE with annul=1, the block SHALL ignore start and remain in FREE.
REQ-015 Operand inputs SHALL be ignored after the latching edge until the FSM returns to FREE.
REQ-016 For a signed operation, the block SHALL latch the absolute values of both operands and record the sign of each.
REQ-017 The magnitude 2^(WIDTH-1) SHALL be handled as the unsigned value 2^(WIDTH-1).
REQ-018 ON SHALL perform one restoring shift-subtract step per cycle on a (2*WIDTH+1)-bit working register and increment the counter.
REQ-019 After exactly WIDTH ON cycles, the FSM SHALL move to END.
REQ-020 ON with annul=1 SHALL move to FREE on the next edge; ready remains 0 and result is not updated.
REQ-021 BYZERO SHALL load result = 0 and move to END on the next edge.
REQ-022 On entering END from ON, the block SHALL load result with the final quotient and remainder.
REQ-023 For signed operations, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-024 Unsigned operations SHALL receive no sign correction.
REQ-025 ready SHALL be 1 exactly while the FSM is in END.
REQ-026 result SHALL be held stable in END and afterwards until the next result load.
REQ-027 END SHALL stay in END while start=1 and move to FREE when start=0.
REQ-028 A new division SHALL be accepted no earlier than the first cycle back in FREE.
REQ-029 Latency: if start is accepted at edge k, ready SHALL be high after edge k+WIDTH+1 (33 for WIDTH=32); for a zero divisor, ready SHALL be high after edge k+2.
REQ-030 0x80000000 / 0xFFFFFFFF signed (WIDTH=32) SHALL give quotient 0x80000000 and remainder 0, with no trap.
REQ-031 A dividend of 0 SHALL give quotient 0 and remainder 0 through the normal ON path.

Reset
REQ-032 When resetn=0 at a rising edge, the block SHALL enter FREE and clear result to 0, ready to 0, the counter to 0 and the working register to 0.
REQ-033 A reset during ON, BYZERO or END SHALL abandon the operation with no result load.
REQ-034 After resetn returns to 1, the block SHALL accept a start on the first edge.
REQ-035 stall SHALL follow its combinational definition during reset.

Verification
REQ-036 The bench SHALL check: DIVU 100/7 -> result {0x00000002, 0x0000000E}, ready first high after edge k+33, stall high from the start cycle until ready.
REQ-037 The bench SHALL check: DIV -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIVU of the same operands -> quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-038 The bench SHALL check: DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; DIVU 5/0 -> result 0, ready after edge k+2.
REQ-039 The bench SHALL check: annul raised on the 10th ON cycle -> FREE next edge, ready never asserted; then DIVU 9/3 -> {0, 3} with full latency.
REQ-040 The bench SHALL check: resetn=0 on the 20th ON cycle -> all outputs 0 next edge; a start on the first post-reset edge completes normally.
REQ-041 The bench SHALL check: start held for 5 cycles in END -> ready and result stable for all 5 cycles; start dropped -> FREE and ready=0 on the next edge.
